vc_test_rand_delay_sink: RTL and testbench

//  Test sink with built-in randomised backpressure: the consuming end of the
//  val/rdy test stream that vc_TestRandDelay drives from the producing side.

---
 rtl/vc_test_rand_delay_sink.sv | 110 +++++++++++
 tb/tb_vc_test_rand_delay_sink.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_test_rand_delay_sink.sv
// Consuming end of a val/rdy test stream: stalls rdy for a random number of
// cycles before each transfer and counts messages that differ from memory m.
module vc_test_rand_delay_sink #(
    parameter int unsigned p_msg_nbits = 8,
    parameter int unsigned p_num_msgs  = 1024,
    parameter logic [31:0] p_seed      = 32'hB7E1_5163
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            max_delay,
    input  logic                   val,
    output logic                   rdy,
    input  logic [p_msg_nbits-1:0] msg,
    output logic [31:0]            num_failed,
    output logic                   done
);

    localparam int unsigned AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
    localparam int unsigned IW = $clog2(p_num_msgs + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(p_num_msgs);
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam int unsigned TW = (p_msg_nbits + 3) / 4;

    typedef enum logic [1:0] {INIT, WAIT, ACCEPT, DONE} state_t;

    state_t                 state, state_next;
    logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];
    logic [p_msg_nbits-1:0] end_mark;
    logic [IW-1:0]          index;
    logic [AW-1:0]          addr;
    logic [32:0]            count, count_next;
    logic [32:0]            draw_wide;
    logic [31:0]            lfsr;
    logic                   xfer;
    logic                   mismatch;

    // The end-of-stream marker is an all-X entry; index past the memory also ends it.
    assign end_mark  = 'x;
    assign addr      = AW'(index);
    assign done      = reset_n && ((index == LAST_IDX) || (m[addr] === end_mark));
    assign draw_wide = {1'b0, lfsr} % ({1'b0, max_delay} + 33'd1);
    assign xfer      = val && rdy;
    assign mismatch  = (msg !== m[addr]);

    always_comb begin
        state_next = state;
        count_next = count;
        rdy        = 1'b0;
        case (state)
            INIT: begin
                state_next = (draw_wide == 33'd0) ? ACCEPT : WAIT;
                count_next = draw_wide;
            end
            WAIT: begin
                count_next = count - 33'd1;
                if (count == 33'd1) state_next = ACCEPT;
            end
            ACCEPT: begin
                rdy = 1'b1;
                if (val) begin
                    state_next = (draw_wide == 33'd0) ? ACCEPT : WAIT;
                    count_next = draw_wide;
                end
            end
            default: state_next = DONE;
        endcase
        // Once the stream has ended nothing else may be accepted.
        if (done) begin
            state_next = DONE;
            rdy        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            index      <= '0;
            num_failed <= '0;
            count      <= '0;
            lfsr       <= p_seed;
        end else begin
            state <= state_next;
            count <= count_next;
            lfsr  <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
            if (xfer) begin
                index <= index + 1'b1;
                if (mismatch && (num_failed != 32'hFFFF_FFFF))
                    num_failed <= num_failed + 32'd1;
            end
        end
    end

    // Line-trace helper: hex msg on a transfer, '#' while stalling, blanks otherwise.
    function automatic logic [8*TW-1:0] trace();
        logic [4*TW-1:0] nib;
        logic [3:0]      digit;
        nib   = (4*TW)'(msg);
        trace = {TW{8'h20}};
        if (val && rdy) begin
            for (int i = 0; i < TW; i++) begin
                digit = nib[4*i +: 4];
                trace[8*i +: 8] = (digit < 4'd10) ? (8'h30 + {4'd0, digit})
                                                  : (8'h57 + {4'd0, digit});
            end
        end else if (!rdy && !done) begin
            trace = {TW{8'h23}};
        end
    endfunction

endmodule

// File: tb/tb_vc_test_rand_delay_sink.sv
// Randomised scoreboard bench for vc_test_rand_delay_sink: a driver queues the
// expected failure count per message, a monitor checks transfers and stall lengths.
module tb_vc_test_rand_delay_sink;

    localparam int unsigned NM = 16;
    localparam logic [31:0] SEED = 32'hB7E1_5163;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] max_delay = 32'd0;
    logic        val = 1'b0;
    logic        rdy;
    logic [7:0]  msg = 8'd0;
    logic [31:0] num_failed;
    logic        done;

    vc_test_rand_delay_sink #(
        .p_msg_nbits(8),
        .p_num_msgs (NM),
        .p_seed     (SEED)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .max_delay (max_delay),
        .val       (val),
        .rdy       (rdy),
        .msg       (msg),
        .num_failed(num_failed),
        .done      (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          q_fail[$];
    logic [7:0]  exp_msgs[$];
    int          stream_len = 0;
    int          drv_idx = 0;
    int          drv_fail = 0;
    int          cyc = 0;

    logic        xfer_seen = 1'b0;
    int          mon_xfers = 0;
    int          gap_cnt = 0;
    int          gap_init = 1;
    logic        gap_armed = 1'b0;
    longint      exp_gap = 0;
    logic [31:0] ref_lfsr = SEED;
    logic        in_init = 1'b1;

    task automatic checkOutput(input string name, input longint actual, input longint required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, required);
        end
    endtask

    // Reference stall generator: Galois LFSR stepped every cycle out of reset,
    // a delay drawn at the first edge after reset and at each transfer edge.
    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            ref_lfsr = SEED;
            in_init  = 1'b1;
        end else begin
            if (in_init || xfer_seen)
                exp_gap = longint'({1'b0, ref_lfsr} % ({1'b0, max_delay} + 33'd1));
            in_init  = 1'b0;
            ref_lfsr = {1'b0, ref_lfsr[31:1]} ^ (ref_lfsr[0] ? 32'h8020_0003 : 32'd0);
        end
    end

    // Monitor: evaluates the edge that has just passed, then samples the next one.
    always @(negedge clk) begin
        if (!reset_n) begin
            xfer_seen = 1'b0;
            mon_xfers = 0;
            gap_cnt   = 0;
            gap_init  = 1;
            gap_armed = 1'b1;
        end else begin
            if (xfer_seen) begin
                mon_xfers++;
                if (q_fail.size() == 0) checkOutput("unexpected_transfer", 1, 0);
                else                    checkOutput("num_failed", num_failed, q_fail.pop_front());
                gap_armed = 1'b1;
                gap_init  = 0;
                gap_cnt   = 0;
            end
            checkOutput("done", done, (mon_xfers == stream_len) ? 1 : 0);
            if (done) begin
                checkOutput("rdy_when_done", rdy, 0);
                gap_armed = 1'b0;
            end else if (!rdy) begin
                gap_cnt++;
            end else if (gap_armed) begin
                checkOutput("stall_len", gap_cnt, exp_gap + gap_init);
                gap_armed = 1'b0;
            end
            xfer_seen = val && rdy;
        end
    end

    task automatic doReset(input logic [31:0] md);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset_rdy", rdy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_failed", num_failed, 0);
        val        = 1'b0;
        max_delay  = md;
        drv_idx    = 0;
        drv_fail   = 0;
        q_fail.delete();
        stream_len = exp_msgs.size();
        for (int i = 0; i < NM; i++) dut.m[i] = 'x;
        for (int i = 0; i < exp_msgs.size(); i++) dut.m[i] = exp_msgs[i];
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] v, input int idle);
        int  waited;
        logic accepted;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        if (drv_idx < exp_msgs.size() && v !== exp_msgs[drv_idx]) drv_fail++;
        drv_idx++;
        q_fail.push_back(drv_fail);
        val      = 1'b1;
        msg      = v;
        waited   = 0;
        accepted = 1'b0;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            accepted = rdy;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!accepted) checkOutput("accept_timeout", 0, 1);
        val = 1'b0;
        msg = 8'd0;
    endtask

    task automatic finishTest();
        repeat (4) @(negedge clk);
        checkOutput("final_done", done, 1);
        checkOutput("final_failed", num_failed, drv_fail);
        checkOutput("queue_empty", q_fail.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] wrongOf(input logic [7:0] v);
        return (v == 8'h55) ? 8'hAA : 8'h55;
    endfunction

    initial begin
        int t0;
        int bound;

        // Back-to-back stream at full throughput.
        exp_msgs = '{8'h01, 8'h02, 8'h03};
        doReset(32'd0);
        foreach (exp_msgs[i]) applyStimulus(exp_msgs[i], 0);
        finishTest();

        // One mismatching message is counted and the stream still ends.
        exp_msgs = '{8'h0A, 8'h0B};
        doReset(32'd0);
        applyStimulus(8'h0A, 0);
        applyStimulus(8'h0C, 0);
        finishTest();

        // A full memory with no end marker, random stalls up to 3 cycles.
        exp_msgs.delete();
        for (int i = 0; i < NM; i++) exp_msgs.push_back(8'(i + 1));
        doReset(32'd3);
        t0 = cyc;
        foreach (exp_msgs[i]) applyStimulus(exp_msgs[i], $urandom_range(0, 2));
        bound = 0;
        while (!done && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        checkOutput("done_within_200", ((cyc - t0) <= 200) ? 1 : 0, 1);
        finishTest();

        // Producer idle while the sink is ready.
        exp_msgs = '{8'h01, 8'h02};
        doReset(32'd0);
        @(posedge clk);
        #1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle_rdy", rdy, 1);
            checkOutput("idle_index", dut.index, 0);
        end
        @(posedge clk);
        #1;
        applyStimulus(8'h01, 0);
        @(negedge clk);
        checkOutput("index_after_one", dut.index, 1);
        @(posedge clk);
        #1;
        applyStimulus(8'h02, 0);
        finishTest();

        // Asynchronous reset in mid-stream, then the whole stream again.
        exp_msgs.delete();
        for (int i = 0; i < 5; i++) exp_msgs.push_back(8'($urandom_range(1, 255)));
        doReset(32'd2);
        applyStimulus(exp_msgs[0], 0);
        applyStimulus(wrongOf(exp_msgs[1]), 0);
        @(negedge clk);
        checkOutput("pre_reset_failed", num_failed, 1);
        @(posedge clk);
        #2;
        doReset(32'd2);
        foreach (exp_msgs[i]) applyStimulus(exp_msgs[i], 0);
        finishTest();

        // Empty stream: done from release onward, never ready.
        exp_msgs.delete();
        doReset(32'd0);
        #1;
        checkOutput("empty_done", done, 1);
        checkOutput("empty_rdy", rdy, 0);
        repeat (5) @(negedge clk);
        finishTest();

        // Random streams with random stall bounds and occasional wrong messages.
        for (int iter = 0; iter < 3; iter++) begin
            int len;
            len = $urandom_range(3, 12);
            exp_msgs.delete();
            for (int i = 0; i < len; i++) exp_msgs.push_back(8'($urandom_range(1, 255)));
            doReset(32'($urandom_range(0, 4)));
            foreach (exp_msgs[i]) begin
                if ($urandom_range(0, 3) == 0) applyStimulus(wrongOf(exp_msgs[i]), $urandom_range(0, 2));
                else                           applyStimulus(exp_msgs[i], $urandom_range(0, 2));
            end
            finishTest();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
